// File: rtl/sled_sched.sv
// sled_sched: round-robin scheduler and MSB-first serialiser for a serial LED shifter chain.
// Define SLED_REFRESH_EN to build the idle auto-resend of the last accepted word.
module sled_sched #(
  parameter int WIDTH       = 16,
  parameter int CLK_DIV     = 4,
  parameter int LATCH_CYC   = 2,
  parameter int REFRESH_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             sclk,
  output logic             sout,
  output logic             slatch,
  output logic             busy,
  output logic             gnt_id,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  localparam int CNT_MAX = (CLK_DIV > LATCH_CYC) ? CLK_DIV : LATCH_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATCH_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  if (WIDTH < 2 || CLK_DIV < 1 || LATCH_CYC < 1 || REFRESH_CYC < 1) begin : g_param_check
    $error("sled_sched: illegal parameter value");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              sclk_q, sclk_d, sout_q, sout_d, slatch_q, slatch_d;
  logic              busy_q, busy_d, gnt_q, gnt_d, pref_q, pref_d;

  logic              grant_vld, grant_id;
  logic [WIDTH-1:0]  grant_word;
  logic              refresh_fire;
  logic [WIDTH-1:0]  refresh_word;

  // Handshake: a word transfers on the rising edge where req_valid[i] && req_ready[i];
  // ready is offered only in IDLE (and out of reset) to the single arbitration winner.
  // pref_q names the port that wins a tie; it flips away from each granted port.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = pref_q;
    if (req_valid == 2'b11) begin
      grant_vld = 1'b1;
      grant_id  = pref_q;
    end else if (req_valid[0]) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (req_valid[1]) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
    if (!rst_n || state_q != IDLE) grant_vld = 1'b0;
    grant_word = grant_id ? req_data1 : req_data0;
    req_ready  = grant_vld ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  end

`ifdef SLED_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYC + 1);
  localparam logic [RW-1:0] IDLE_LAST = RW'(REFRESH_CYC - 1);

  logic [WIDTH-1:0] last_q, last_d;
  logic             have_last_q, have_last_d;
  logic [RW-1:0]    idle_q, idle_d;

  always_comb begin
    last_d       = last_q;
    have_last_d  = have_last_q;
    idle_d       = '0;
    refresh_fire = 1'b0;
    if (grant_vld) begin
      last_d      = grant_word;
      have_last_d = 1'b1;
    end
    // Only an unbroken run of idle, request-free cycles counts toward a resend.
    if (state_q == IDLE && req_valid == 2'b00 && have_last_q) begin
      if (idle_q == IDLE_LAST) refresh_fire = 1'b1;
      else idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= '0;
      have_last_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      last_q      <= last_d;
      have_last_q <= have_last_d;
      idle_q      <= idle_d;
    end
  end

  assign refresh_word = last_q;
`else
  assign refresh_fire = 1'b0;
  assign refresh_word = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    sout_d   = sout_q;
    slatch_d = slatch_q;
    busy_d   = busy_q;
    gnt_d    = gnt_q;
    pref_d   = pref_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld || refresh_fire) begin
          shreg_d = grant_vld ? grant_word : refresh_word;
          sout_d  = shreg_d[WIDTH-1];
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          bit_d   = BIT_LAST;
          cnt_d   = '0;
          state_d = SHIFT_LO;
          if (grant_vld) begin
            gnt_d  = grant_id;
            pref_d = ~grant_id;
          end
        end
      end
      SHIFT_LO: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          if (bit_q == '0) begin
            slatch_d = 1'b1;
            sout_d   = 1'b0;
            state_d  = LATCH;
          end else begin
            bit_d   = bit_q - 1'b1;
            sout_d  = shreg_q[WIDTH-2];
            state_d = SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d    = '0;
          slatch_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      sout_q   <= 1'b0;
      slatch_q <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= 1'b0;
      pref_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      sout_q   <= sout_d;
      slatch_q <= slatch_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      pref_q   <= pref_d;
    end
  end

  assign sclk      = sclk_q;
  assign sout      = sout_q;
  assign slatch    = slatch_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sled_sched.sv
// Directed testbench for sled_sched: a requester driver, a frame-decoding monitor on the
// chain pins, and one task per scenario with inline comparisons.
module tb_sled_sched;
  localparam int W     = 16;
  localparam int DIV   = 2;
  localparam int LAT   = 2;
  localparam int REF   = 100;
  localparam int FRAME = 66;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid, req_ready, dbg_state;
  logic [W-1:0] req_data0, req_data1;
  logic         sclk, sout, slatch, busy, gnt_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] word;
    logic         gnt;
    logic [1:0]   rdy;
    int           edges, busy_cyc, latch_cyc, hi_cyc, glitch, start;
  } frame_t;

  frame_t       fr_q[$];
  logic [W-1:0] q0[$], q1[$];
  logic [1:0]   acc;
  int cyc = 0, aborts = 0, ready_cyc = 0, ready_busy = 0, stray_latch = 0, cur_edges = 0;

  sled_sched #(.WIDTH(W), .CLK_DIV(DIV), .LATCH_CYC(LAT), .REFRESH_CYC(REF)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_ready(req_ready), .sclk(sclk), .sout(sout),
    .slatch(slatch), .busy(busy), .gnt_id(gnt_id), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- requester driver ----------------
  initial begin : requesters
    req_valid = 2'b00; req_data0 = '0; req_data1 = '0; acc = 2'b00;
    forever begin
      @(negedge clk);
      if (acc[0]) void'(q0.pop_front());
      if (acc[1]) void'(q1.pop_front());
      req_valid = {q1.size() > 0, q0.size() > 0};
      req_data0 = (q0.size() > 0) ? q0[0] : '0;
      req_data1 = (q1.size() > 0) ? q1[0] : '0;
      #2 acc = req_valid & req_ready & {2{rst_n}};
    end
  end

  // ---------------- chain monitor ----------------
  initial begin : monitor
    logic in_frame, sclk_prev, sout_prev;
    logic [1:0] rdy_prev;
    frame_t cur;
    in_frame = 1'b0; sclk_prev = 1'b0; sout_prev = 1'b0; rdy_prev = 2'b00;
    cur = '{word: '0, gnt: 1'b0, rdy: 2'b00, edges: 0, busy_cyc: 0, latch_cyc: 0, hi_cyc: 0, glitch: 0, start: 0};
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (!rst_n) begin
        if (in_frame) aborts++;
        in_frame = 1'b0; sclk_prev = 1'b0; sout_prev = 1'b0; rdy_prev = 2'b00; cur_edges = 0;
      end else begin
        if (req_ready != 2'b00) begin
          ready_cyc++;
          if (busy) ready_busy++;
        end
        if (busy && !in_frame) begin
          in_frame = 1'b1; cur_edges = 0;
          cur = '{word: '0, gnt: gnt_id, rdy: rdy_prev, edges: 0, busy_cyc: 0, latch_cyc: 0, hi_cyc: 0, glitch: 0, start: cyc};
        end
        if (in_frame && busy) begin
          cur.busy_cyc += 1;
          if (sclk && !sclk_prev) begin
            cur.word = {cur.word[W-2:0], sout};
            cur.edges += 1;
            cur_edges++;
          end
          if (sclk) cur.hi_cyc += 1;
          if (sclk && sclk_prev && sout !== sout_prev) cur.glitch += 1;
          if (slatch) cur.latch_cyc += 1;
        end else if (in_frame) begin
          fr_q.push_back(cur);
          in_frame = 1'b0; cur_edges = 0;
        end
        if (slatch && !in_frame) stray_latch++;
        rdy_prev = req_ready; sclk_prev = sclk; sout_prev = sout;
      end
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (fr_q.size() < n && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b expected 0", sout); end
    checks++; if (slatch !== 1'b0) begin errors++; $display("FAIL reset_slatch: got %b expected 0", slatch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (gnt_id !== 1'b0) begin errors++; $display("FAIL reset_gnt_id: got %b expected 0", gnt_id); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #3;
    checks++; if (dbg_state !== 2'b00) begin errors++; $display("FAIL reset_state_idle: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_single_frame;
    frame_t f;
    fr_q.delete(); ready_cyc = 0; ready_busy = 0; stray_latch = 0;
    @(posedge clk); #1 q0.push_back(16'hA5C3);
    wait_frames(1, 200);
    checks++; if (fr_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", fr_q.size()); end
    if (fr_q.size() >= 1) begin
      f = fr_q[0];
      checks++; if (f.word !== 16'hA5C3) begin errors++; $display("FAIL single_bits: got %h expected a5c3", f.word); end
      checks++; if (f.edges != 16) begin errors++; $display("FAIL single_edges: got %0d expected 16", f.edges); end
      checks++; if (f.busy_cyc != FRAME) begin errors++; $display("FAIL single_busy_len: got %0d expected %0d", f.busy_cyc, FRAME); end
      checks++; if (f.latch_cyc != LAT) begin errors++; $display("FAIL single_latch_len: got %0d expected %0d", f.latch_cyc, LAT); end
      checks++; if (f.hi_cyc != 32) begin errors++; $display("FAIL single_sclk_high: got %0d expected 32", f.hi_cyc); end
      checks++; if (f.glitch != 0) begin errors++; $display("FAIL single_sout_stable: got %0d expected 0", f.glitch); end
      checks++; if (f.gnt !== 1'b0) begin errors++; $display("FAIL single_gnt: got %b expected 0", f.gnt); end
      checks++; if (f.rdy !== 2'b01) begin errors++; $display("FAIL single_ready_val: got %b expected 01", f.rdy); end
    end
    checks++; if (ready_cyc != 1) begin errors++; $display("FAIL single_ready_cycles: got %0d expected 1", ready_cyc); end
    checks++; if (stray_latch != 0) begin errors++; $display("FAIL single_stray_latch: got %0d expected 0", stray_latch); end
  endtask

  task automatic test_contention;
    logic [W-1:0] exp_w [4];
    logic         exp_g [4];
    exp_w = '{16'h1111, 16'h3333, 16'h2222, 16'h4444};
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0;
    @(posedge clk); #1 q0.push_back(16'h0001); q1.push_back(16'h8000);
    @(negedge clk); #3;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL cont_ready_in_reset: got %b expected 00", req_ready); end
    fr_q.delete();
    @(negedge clk); rst_n = 1'b1;
    wait_frames(2, 400);
    checks++; if (fr_q.size() != 2) begin errors++; $display("FAIL cont_count: got %0d expected 2", fr_q.size()); end
    if (fr_q.size() >= 2) begin
      checks++; if (fr_q[0].word !== 16'h0001 || fr_q[0].gnt !== 1'b0 || fr_q[0].rdy !== 2'b01) begin errors++; $display("FAIL cont_first: got %h/%b/%b expected 0001/0/01", fr_q[0].word, fr_q[0].gnt, fr_q[0].rdy); end
      checks++; if (fr_q[1].word !== 16'h8000 || fr_q[1].gnt !== 1'b1 || fr_q[1].rdy !== 2'b10) begin errors++; $display("FAIL cont_second: got %h/%b/%b expected 8000/1/10", fr_q[1].word, fr_q[1].gnt, fr_q[1].rdy); end
    end
    fr_q.delete();
    @(posedge clk); #1 q0.push_back(16'h1111); q0.push_back(16'h2222); q1.push_back(16'h3333); q1.push_back(16'h4444);
    wait_frames(4, 600);
    checks++; if (fr_q.size() != 4) begin errors++; $display("FAIL cont_alt_count: got %0d expected 4", fr_q.size()); end
    for (int i = 0; i < 4 && i < fr_q.size(); i++) begin
      checks++; if (fr_q[i].word !== exp_w[i] || fr_q[i].gnt !== exp_g[i]) begin errors++; $display("FAIL cont_alt_%0d: got %h/%b expected %h/%b", i, fr_q[i].word, fr_q[i].gnt, exp_w[i], exp_g[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_w [4];
    exp_w = '{16'hDEAD, 16'hBEEF, 16'h0F0F, 16'hF0F0};
    fr_q.delete(); ready_cyc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) q1.push_back(exp_w[i]);
    wait_frames(4, 600);
    checks++; if (fr_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", fr_q.size()); end
    checks++; if (ready_cyc != 4) begin errors++; $display("FAIL b2b_ready_cycles: got %0d expected 4", ready_cyc); end
    for (int i = 0; i < 4 && i < fr_q.size(); i++) begin
      checks++; if (fr_q[i].word !== exp_w[i] || fr_q[i].gnt !== 1'b1) begin errors++; $display("FAIL b2b_word_%0d: got %h/%b expected %h/1", i, fr_q[i].word, fr_q[i].gnt, exp_w[i]); end
      if (i > 0) begin
        checks++; if (fr_q[i].start - fr_q[i-1].start != FRAME + 1) begin errors++; $display("FAIL b2b_gap_%0d: got %0d expected %0d", i, fr_q[i].start - fr_q[i-1].start, FRAME + 1); end
      end
    end
  endtask

  task automatic test_busy_block;
    int k;
    fr_q.delete(); ready_busy = 0;
    @(posedge clk); #1 q1.push_back(16'hC0DE);
    k = 0;
    do begin @(negedge clk); #2; k++; end while (!busy && k < 20);
    @(posedge clk); #1 q0.push_back(16'h1357);
    @(negedge clk); #3;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL busy_ready_blocked: got %b expected 00", req_ready); end
    wait_frames(2, 400);
    checks++; if (fr_q.size() != 2) begin errors++; $display("FAIL busy_count: got %0d expected 2", fr_q.size()); end
    checks++; if (ready_busy != 0) begin errors++; $display("FAIL busy_ready_during_frame: got %0d expected 0", ready_busy); end
    if (fr_q.size() >= 2) begin
      checks++; if (fr_q[0].word !== 16'hC0DE || fr_q[0].gnt !== 1'b1) begin errors++; $display("FAIL busy_first: got %h/%b expected c0de/1", fr_q[0].word, fr_q[0].gnt); end
      checks++; if (fr_q[1].word !== 16'h1357 || fr_q[1].gnt !== 1'b0 || fr_q[1].rdy !== 2'b01) begin errors++; $display("FAIL busy_second: got %h/%b/%b expected 1357/0/01", fr_q[1].word, fr_q[1].gnt, fr_q[1].rdy); end
      checks++; if (fr_q[1].start - fr_q[0].start != FRAME + 1) begin errors++; $display("FAIL busy_gap: got %0d expected %0d", fr_q[1].start - fr_q[0].start, FRAME + 1); end
    end
  endtask

`ifdef SLED_REFRESH_EN
  task automatic test_refresh;
    fr_q.delete();
    @(posedge clk); #1 q0.push_back(16'h1234);
    wait_frames(1, 200);
    wait_frames(2, 300);
    checks++; if (fr_q.size() != 2) begin errors++; $display("FAIL refresh_count: got %0d expected 2", fr_q.size()); end
    if (fr_q.size() >= 2) begin
      checks++; if (fr_q[1].word !== 16'h1234 || fr_q[1].gnt !== 1'b0 || fr_q[1].rdy !== 2'b00) begin errors++; $display("FAIL refresh_frame: got %h/%b/%b expected 1234/0/00", fr_q[1].word, fr_q[1].gnt, fr_q[1].rdy); end
      checks++; if (fr_q[1].start - fr_q[0].start != FRAME + REF) begin errors++; $display("FAIL refresh_delay: got %0d expected %0d", fr_q[1].start - fr_q[0].start, FRAME + REF); end
    end
    repeat (98) @(posedge clk);
    #1 q1.push_back(16'h0F0F);
    wait_frames(3, 200);
    checks++; if (fr_q.size() != 3) begin errors++; $display("FAIL refresh_preempt_count: got %0d expected 3", fr_q.size()); end
    if (fr_q.size() >= 3) begin
      checks++; if (fr_q[2].word !== 16'h0F0F || fr_q[2].gnt !== 1'b1 || fr_q[2].rdy !== 2'b10) begin errors++; $display("FAIL refresh_preempt_frame: got %h/%b/%b expected 0f0f/1/10", fr_q[2].word, fr_q[2].gnt, fr_q[2].rdy); end
      checks++; if (fr_q[2].start - fr_q[1].start != FRAME + 99) begin errors++; $display("FAIL refresh_preempt_time: got %0d expected %0d", fr_q[2].start - fr_q[1].start, FRAME + 99); end
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    int k;
    fr_q.delete(); aborts = 0; stray_latch = 0;
    @(posedge clk); #1 q0.push_back(16'hFFFF);
    k = 0;
    do begin @(negedge clk); #2; k++; end while (cur_edges < 7 && k < 200);
    checks++; if (cur_edges != 7) begin errors++; $display("FAIL mid_edge7_reached: got %0d expected 7", cur_edges); end
    checks++; if (sclk !== 1'b1 || sout !== 1'b1) begin errors++; $display("FAIL mid_pre_reset: got sclk %b sout %b expected 1 1", sclk, sout); end
    rst_n = 1'b0;
    #1;
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk_async: got %b expected 0", sclk); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL mid_sout_async: got %b expected 0", sout); end
    checks++; if (slatch !== 1'b0) begin errors++; $display("FAIL mid_slatch_async: got %b expected 0", slatch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async: got %b expected 0", busy); end
    checks++; if (dbg_state !== 2'b00) begin errors++; $display("FAIL mid_state_async: got %0d expected 0", dbg_state); end
    repeat (3) @(negedge clk);
    #3;
    checks++; if (aborts != 1 || fr_q.size() != 0) begin errors++; $display("FAIL mid_abandoned: got aborts %0d frames %0d expected 1 0", aborts, fr_q.size()); end
    checks++; if (stray_latch != 0) begin errors++; $display("FAIL mid_no_latch: got %0d expected 0", stray_latch); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 q0.push_back(16'h3C5A);
    wait_frames(1, 200);
    checks++; if (fr_q.size() != 1) begin errors++; $display("FAIL mid_recover_count: got %0d expected 1", fr_q.size()); end
    if (fr_q.size() >= 1) begin
      checks++; if (fr_q[0].word !== 16'h3C5A || fr_q[0].edges != 16 || fr_q[0].latch_cyc != LAT || fr_q[0].busy_cyc != FRAME) begin
        errors++; $display("FAIL mid_recover_frame: got %h/%0d/%0d/%0d expected 3c5a/16/%0d/%0d", fr_q[0].word, fr_q[0].edges, fr_q[0].latch_cyc, fr_q[0].busy_cyc, LAT, FRAME);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin : main
    test_reset();
    test_single_frame();
    test_contention();
    test_back_to_back();
    test_busy_block();
`ifdef SLED_REFRESH_EN
    test_refresh();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
